// File: rtl/post_stream_packer.sv
// Packs 32-bit post-process beats into 64-bit AXI4-Stream words behind a 512-word FWFT FIFO.
// Frame/drop counters are built only when POST_PACK_STATS_EN is defined.
module post_stream_packer #(
  parameter int IN_BITS        = 32,
  parameter int OUT_BITS       = 64,
  parameter int FIFO_ADDR_BITS = 9
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [IN_BITS-1:0]    in_data,
  input  logic                  in_valid,
  input  logic                  in_eol,
  input  logic                  in_eof,
  output logic [OUT_BITS-1:0]   m_axis_tdata,
  output logic [OUT_BITS/8-1:0] m_axis_tkeep,
  output logic [1:0]            m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int KEEP_BITS  = OUT_BITS / 8;
  localparam int ENTRY_BITS = 3 + KEEP_BITS + OUT_BITS;
  localparam int DEPTH      = 1 << FIFO_ADDR_BITS;

  typedef enum logic {RUN, DROP} state_t;

  state_t                    state_q, state_d;
  logic                      half_q;
  logic                      sof_q;
  logic [IN_BITS-1:0]        low_q;
  logic                      word_done;
  logic                      write_en;
  logic                      overflow_hit;
  logic [OUT_BITS-1:0]       word_data;
  logic [KEEP_BITS-1:0]      word_keep;
  logic [ENTRY_BITS-1:0]     entry;
  logic [ENTRY_BITS-1:0]     mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   mem_count;
  logic [FIFO_ADDR_BITS:0]   occupancy;
  logic                      fifo_full;
  logic                      pop;
  logic                      load;

  always_comb begin
    if (half_q) begin
      word_data = {in_data, low_q};
      word_keep = '1;
    end else begin
      word_data = {{(OUT_BITS-IN_BITS){1'b0}}, in_data};
      word_keep = {{(KEEP_BITS-KEEP_BITS/2){1'b0}}, {(KEEP_BITS/2){1'b1}}};
    end
  end

  assign entry = {in_eof, sof_q, in_eol, word_keep, word_data};

  // The word held in the output register still counts against the 512-word capacity.
  assign occupancy = mem_count + (FIFO_ADDR_BITS+1)'(m_axis_tvalid);
  assign fifo_full = (occupancy == (FIFO_ADDR_BITS+1)'(DEPTH));
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign load      = (!m_axis_tvalid || m_axis_tready) && (mem_count != '0);

  always_comb begin
    state_d      = state_q;
    word_done    = 1'b0;
    write_en     = 1'b0;
    overflow_hit = 1'b0;
    case (state_q)
      RUN: begin
        if (in_valid && (half_q || in_eol)) begin
          word_done = 1'b1;
          if (fifo_full && !pop) begin
            overflow_hit = 1'b1;
            if (!in_eof) state_d = DROP;
          end else begin
            write_en = 1'b1;
          end
        end
      end
      DROP: begin
        if (in_valid && in_eof) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      half_q   <= 1'b0;
      sof_q    <= 1'b1;
      low_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (state_q == RUN && in_valid) begin
        if (word_done) begin
          half_q <= 1'b0;
          sof_q  <= in_eof;
        end else begin
          low_q  <= in_data;
          half_q <= 1'b1;
        end
      end else if (state_q == DROP && in_valid && in_eof) begin
        half_q <= 1'b0;
        sof_q  <= 1'b1;
      end
      if (overflow_hit) overflow <= 1'b1;
    end
  end

`ifdef POST_PACK_STATS_EN
  logic frame_done;
  logic drop_done;

  assign frame_done = write_en && in_eof;
  assign drop_done  = (overflow_hit && in_eof) || (state_q == DROP && in_valid && in_eof);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (drop_done)  drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

  always_ff @(posedge aclk) begin
    if (write_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (load)     rd_ptr <= rd_ptr + 1'b1;
      case ({write_en, load})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  // First-word-fall-through register: refills whenever empty or being consumed.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr];
    end else if (pop) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
